// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared GF(2^8) helpers, widths and FSM encoding for the AES inverse-mix block
package aes_pkg;

  localparam logic [7:0] GF_POLY   = 8'h1b;
  localparam int         COL_W     = 32;
  localparam int         STATE_W   = 128;
  localparam int         CNT_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // multiply by x (0x02) in GF(2^8), reducing with the AES polynomial
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // general GF(2^8) multiply by shift-and-add; constant b folds to a few XORs
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_inv_mixcol_col.sv
// rtl/aes_inv_mixcol_col.sv - combinational AES InvMixColumns on one 32-bit column
module aes_inv_mixcol_col
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  output logic [COL_W-1:0] col_out
);

  logic [7:0] d0, d1, d2, d3;
  logic [7:0] o0, o1, o2, o3;

  // byte 0 of a column sits in the low bits
  assign d0 = col_in[7:0];
  assign d1 = col_in[15:8];
  assign d2 = col_in[23:16];
  assign d3 = col_in[31:24];

  assign o0 = gf_mul(d0, 8'h0e) ^ gf_mul(d1, 8'h0b) ^ gf_mul(d2, 8'h0d) ^ gf_mul(d3, 8'h09);
  assign o1 = gf_mul(d0, 8'h09) ^ gf_mul(d1, 8'h0e) ^ gf_mul(d2, 8'h0b) ^ gf_mul(d3, 8'h0d);
  assign o2 = gf_mul(d0, 8'h0d) ^ gf_mul(d1, 8'h09) ^ gf_mul(d2, 8'h0e) ^ gf_mul(d3, 8'h0b);
  assign o3 = gf_mul(d0, 8'h0b) ^ gf_mul(d1, 8'h0d) ^ gf_mul(d2, 8'h09) ^ gf_mul(d3, 8'h0e);

  assign col_out = {o3, o2, o1, o0};

endmodule

// File: rtl/aes_128_inv_mixcol_seq.sv
// rtl/aes_128_inv_mixcol_seq.sv - sequential 128-bit InvMixColumns, one column per cycle; optional round-key XOR under AES_INV_MIXCOL_ADDKEY_EN
module aes_128_inv_mixcol_seq
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               kill,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  input  logic               in_bypass,
`ifdef AES_INV_MIXCOL_ADDKEY_EN
  input  logic [STATE_W-1:0] round_key,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               bypass_q;
  logic [STATE_W-1:0] data_q;
  logic [STATE_W-1:0] capture_value;
  logic               capture;
  logic               col_we;
  logic [COL_W-1:0]   col_sel;
  logic [COL_W-1:0]   col_mixed;
  logic [COL_W-1:0]   col_res;

`ifdef AES_INV_MIXCOL_ADDKEY_EN
  // key is folded in at capture so both the mix and bypass paths see it
  assign capture_value = in_data ^ round_key;
`else
  assign capture_value = in_data;
`endif

  assign col_sel = data_q[{cnt_q, 5'd0} +: COL_W];
  assign col_res = bypass_q ? col_sel : col_mixed;

  aes_inv_mixcol_col u_col (
    .col_in  (col_sel),
    .col_out (col_mixed)
  );

  // state register; kill behaves like a synchronous return to idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else if (kill) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state and handshake decode
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    capture   = 1'b0;
    col_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        col_we = 1'b1;
        if (cnt_q == 2'd3) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // datapath: capture the input, then write one result column per busy cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      bypass_q <= 1'b0;
      data_q   <= '0;
      out_data <= '0;
    end else if (kill) begin
      cnt_q    <= '0;
      out_data <= '0;
    end else begin
      if (capture) begin
        data_q   <= capture_value;
        bypass_q <= in_bypass;
        cnt_q    <= '0;
      end
      if (col_we) begin
        out_data[{cnt_q, 5'd0} +: COL_W] <= col_res;
        cnt_q                            <= cnt_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_128_inv_mixcol_seq.sv
// tb/tb_aes_128_inv_mixcol_seq.sv - directed and round-trip checks for aes_128_inv_mixcol_seq
module tb_aes_128_inv_mixcol_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         kill;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef AES_INV_MIXCOL_ADDKEY_EN
  logic [127:0] round_key;
`endif

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [127:0] din;
    logic         byp;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl[8];

  aes_128_inv_mixcol_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .kill      (kill),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_bypass (in_bypass),
`ifdef AES_INV_MIXCOL_ADDKEY_EN
    .round_key (round_key),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3, o0, o1, o2, o3;
    a0 = c[7:0]; a1 = c[15:8]; a2 = c[23:16]; a3 = c[31:24];
    o0 = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    o1 = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    o2 = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    o3 = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    return {o3, o2, o1, o0};
  endfunction

  function automatic logic [127:0] fwd_mix(input logic [127:0] s);
    return {fwd_col(s[127:96]), fwd_col(s[95:64]), fwd_col(s[63:32]), fwd_col(s[31:0])};
  endfunction

  // one full transaction; in_valid stays high with junk data after capture to prove it is ignored
  task automatic transact(input logic [127:0] d, input logic b, input int bp,
                          output logic [127:0] res, output int lat,
                          output logic held, output logic post_valid);
    int g;
    g = 0;
    while (!in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    in_valid  = 1'b1;
    in_data   = d;
    in_bypass = b;
    @(negedge clk);
    in_data   = ~d;
    in_bypass = ~b;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    res  = out_data;
    held = 1'b1;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (out_data !== res || out_valid !== 1'b1) held = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready  = 1'b0;
    in_valid   = 1'b0;
    post_valid = out_valid;
  endtask

  initial begin
    logic [127:0] res;
    logic [127:0] x;
    int           lat;
    logic         held;
    logic         pv;
    int           g;

    tbl[0] = '{din: {96'h0, 32'hbca14d8e}, byp: 1'b0, exp: {96'h0, 32'h455313db}};
    tbl[1] = '{din: {4{32'h9d58dc9f}},     byp: 1'b0, exp: {4{32'h5c220af2}}};
    tbl[2] = '{din: {4{32'hc6c6c6c6}},     byp: 1'b0, exp: {4{32'hc6c6c6c6}}};
    tbl[3] = '{din: {4{32'h01010101}},     byp: 1'b0, exp: {4{32'h01010101}}};
    tbl[4] = '{din: 128'h00112233445566778899aabbccddeeff, byp: 1'b1,
               exp: 128'h00112233445566778899aabbccddeeff};
    tbl[5] = '{din: {32'h0, 32'hbca14d8e, 64'h0}, byp: 1'b0, exp: {32'h0, 32'h455313db, 64'h0}};
    tbl[6] = '{din: {32'hc6c6c6c6, 32'h9d58dc9f, 32'h01010101, 32'hbca14d8e}, byp: 1'b0,
               exp: {32'hc6c6c6c6, 32'h5c220af2, 32'h01010101, 32'h455313db}};
    tbl[7] = '{din: {4{32'h9d58dc9f}},     byp: 1'b1, exp: {4{32'h9d58dc9f}}};

    rst_n     = 1'b0;
    kill      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_bypass = 1'b0;
    out_ready = 1'b0;
`ifdef AES_INV_MIXCOL_ADDKEY_EN
    round_key = '0;
`endif
    repeat (2) @(negedge clk);
    check("reset_out_valid", 128'(out_valid), 128'h0);
    check("reset_out_data", out_data, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 128'(in_ready), 128'h1);

    for (int i = 0; i < 8; i++) begin
      transact(tbl[i].din, tbl[i].byp, i % 3, res, lat, held, pv);
      check($sformatf("vec%0d_data", i), res, tbl[i].exp);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'd4);
      check($sformatf("vec%0d_hold", i), 128'(held), 128'h1);
      check($sformatf("vec%0d_valid_drop", i), 128'(pv), 128'h0);
    end

    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_out_ready_valid", 128'(out_valid), 128'h0);
    check("idle_out_ready_ready", 128'(in_ready), 128'h1);

    in_valid = 1'b1;
    in_data  = tbl[1].din;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_out_valid", 128'(out_valid), 128'h0);
    check("kill_out_data", out_data, 128'h0);
    check("kill_in_ready", 128'(in_ready), 128'h1);
    repeat (5) @(negedge clk);
    check("kill_no_result", 128'(out_valid), 128'h0);
    transact(tbl[6].din, 1'b0, 1, res, lat, held, pv);
    check("after_kill_data", res, tbl[6].exp);
    check("after_kill_latency", 128'(lat), 128'd4);

    in_valid = 1'b1;
    in_data  = tbl[0].din;
    @(negedge clk);
    in_valid = 1'b0;
    g = 0;
    while (!out_valid && g < 10) begin
      @(negedge clk);
      g++;
    end
    check("pre_reset_done", 128'(out_valid), 128'h1);
    rst_n = 1'b0;
    #1;
    check("reset_done_out_valid", 128'(out_valid), 128'h0);
    check("reset_done_out_data", out_data, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_done_in_ready", 128'(in_ready), 128'h1);
    check("reset_done_no_result", 128'(out_valid), 128'h0);
    transact(tbl[1].din, 1'b0, 0, res, lat, held, pv);
    check("after_reset_data", res, tbl[1].exp);

    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      transact(fwd_mix(x), 1'b0, int'($urandom_range(0, 5)), res, lat, held, pv);
      check($sformatf("roundtrip%0d", i), res, x);
      if (lat != 4 || held !== 1'b1) check($sformatf("roundtrip%0d_timing", i), 128'(lat), 128'd4);
    end

`ifdef AES_INV_MIXCOL_ADDKEY_EN
    x = {$urandom, $urandom, $urandom, $urandom};
    round_key = x;
    transact(x, 1'b0, 0, res, lat, held, pv);
    check("addkey_mix_zero", res, 128'h0);
    transact(x, 1'b1, 0, res, lat, held, pv);
    check("addkey_bypass_zero", res, 128'h0);
    round_key = 128'h00000000000000000000000001010101;
    transact(128'h0, 1'b1, 0, res, lat, held, pv);
    check("addkey_bypass_key", res, 128'h00000000000000000000000001010101);
    round_key = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
